// File: rtl/wb_ld_merge.sv
// Merges pipeline writeback and load returns onto one register-file write port via an in-order load queue.
// Optional feature macro LQ_BYPASS_EN: a load reaching an idle, empty queue writes in its arrival cycle.
module wb_ld_merge #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_a,
    input  logic                   p4_wben,
    input  logic [AW-1:0]          p4_wba,
    input  logic [DW-1:0]          p4_wbdata,
    input  logic                   ldvalid,
    input  logic [AW-1:0]          regadr,
    input  logic [DW-1:0]          drd,
    input  logic [AW-1:0]          s1a,
    input  logic [AW-1:0]          fs2a,
    output logic                   wben,
    output logic [AW-1:0]          wba,
    output logic [DW-1:0]          wbdata,
    output logic                   ld_hold,
    output logic                   lq_hit_a,
    output logic                   lq_hit_b,
    output logic [$clog2(DEPTH):0] lq_count,
    output logic                   lq_ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic          valid;
        logic          live;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        ent_q [DEPTH];
    entry_t        ent_d [DEPTH];
    entry_t        head;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          full, ld_acc, ld_kill, pop, push, bypass;
    logic          wben_raw, hit_a, hit_b;

    assign full    = (cnt_q == CW'(DEPTH));
    assign head    = ent_q[rd_q];
    assign ld_acc  = ldvalid && (int'(regadr) < 32) && !full;
    // A writeback in the same cycle is younger than the returning load, so the load is dropped.
    assign ld_kill = p4_wben && (regadr == p4_wba);
    assign pop     = !p4_wben && (cnt_q != '0);

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        bypass = 1'b0;
`ifdef LQ_BYPASS_EN
        bypass = !p4_wben && (cnt_q == '0) && ld_acc;
`endif
        push = ld_acc && !bypass && !ld_kill;
    end

    always_comb begin
        wben_raw = 1'b0;
        wba      = '0;
        wbdata   = '0;
        if (p4_wben) begin
            wben_raw = 1'b1;
            wba      = p4_wba;
            wbdata   = p4_wbdata;
        end else if (pop) begin
            wben_raw = head.live;
            wba      = head.addr;
            wbdata   = head.data;
        end else if (bypass) begin
            wben_raw = 1'b1;
            wba      = regadr;
            wbdata   = drd;
        end
    end

    always_comb begin
        ent_d = ent_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        ovf_d = ovf_q || (ldvalid && full);
        if (p4_wben) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].valid && ent_q[i].addr == p4_wba) ent_d[i].live = 1'b0;
            end
        end
        if (pop) begin
            ent_d[rd_q].valid = 1'b0;
            ent_d[rd_q].live  = 1'b0;
            rd_d              = rd_q + 1'b1;
        end
        if (push) begin
            ent_d[wr_q] = '{valid: 1'b1, live: 1'b1, addr: regadr, data: drd};
            wr_d        = wr_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    // NOTE: nonblocking assignments here keep every flop sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            // NOTE: only the flag bits are reset; addr/data are never read while valid=0.
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].valid <= 1'b0;
                ent_q[i].live  <= 1'b0;
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            ent_q <= ent_d;
        end
    end

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && ent_q[i].live && ent_q[i].addr == s1a)  hit_a = 1'b1;
            if (ent_q[i].valid && ent_q[i].live && ent_q[i].addr == fs2a) hit_b = 1'b1;
        end
    end

    assign wben     = wben_raw && !rst_a;
    assign ld_hold  = full && !rst_a;
    assign lq_hit_a = hit_a && !rst_a;
    assign lq_hit_b = hit_b && !rst_a;
    assign lq_count = cnt_q;
    assign lq_ovf   = ovf_q;
endmodule
